// File: rtl/vga_rect_filler_if.sv
// rtl/vga_rect_filler_if.sv - rectangle command handshake and pixel-write port bundle
interface vga_rect_filler_if #(
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [7:0]          x0;
  logic [6:0]          y0;
  logic [7:0]          w;
  logic [6:0]          h;
  logic [COLOUR_W-1:0] colour_in;
  logic [7:0]          x;
  logic [6:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, x0, y0, w, h, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/vga_rect_filler.sv
// rtl/vga_rect_filler.sv - clipped rectangle fill, one row-major pixel write per clock
module vga_rect_filler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic              Clock,
  input  logic              Resetn,
  vga_rect_filler_if.slave  bus
);
  localparam logic [8:0] SW = 9'(SCREEN_W);
  localparam logic [7:0] SH = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state;
  logic [7:0] x_start;
  logic [7:0] x_last;
  logic [6:0] y_last;

  logic [8:0] x_end;
  logic [7:0] y_end;
  logic [7:0] w_eff;
  logic [6:0] h_eff;

  // Clip against the screen edge using widened sums so x0+w never wraps.
  always_comb begin
    x_end = {1'b0, bus.x0} + {1'b0, bus.w};
    y_end = {1'b0, bus.y0} + {1'b0, bus.h};
    if ({1'b0, bus.x0} >= SW)
      w_eff = '0;
    else if (x_end > SW)
      w_eff = 8'(SW - {1'b0, bus.x0});
    else
      w_eff = bus.w;
    if ({1'b0, bus.y0} >= SH)
      h_eff = '0;
    else if (y_end > SH)
      h_eff = 7'(SH - {1'b0, bus.y0});
    else
      h_eff = bus.h;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      x_start    <= '0;
      x_last     <= '0;
      y_last     <= '0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (w_eff != '0 && h_eff != '0) begin
              state      <= DRAW;
              x_start    <= bus.x0;
              x_last     <= bus.x0 + w_eff - 8'd1;
              y_last     <= bus.y0 + h_eff - 7'd1;
              bus.x      <= bus.x0;
              bus.y      <= bus.y0;
              bus.colour <= COLOUR_W'(bus.colour_in);
              bus.plot   <= 1'b1;
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        DRAW: begin
          if (bus.x == x_last && bus.y == y_last) begin
            state    <= DONE;
            bus.plot <= 1'b0;
            bus.done <= 1'b1;
          end else if (bus.x == x_last) begin
            bus.x <= x_start;
            bus.y <= bus.y + 7'd1;
          end else begin
            bus.x <= bus.x + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.plot <= 1'b0;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_rect_filler.sv
// tb/tb_vga_rect_filler.sv - vector table, random commands and reset corner cases for vga_rect_filler
module tb_vga_rect_filler;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;

  vga_rect_filler_if #(.COLOUR_W(3)) bus ();

  vga_rect_filler #(
    .SCREEN_W(160),
    .SCREEN_H(120),
    .COLOUR_W(3)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x0, y0, w, h, col;
    int inj_a, inj_b;
    int n, dcyc, first, last;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic scramble_operands();
    bus.x0        = 8'($urandom);
    bus.y0        = 7'($urandom);
    bus.w         = 8'($urandom);
    bus.h         = 7'($urandom);
    bus.colour_in = 3'($urandom);
  endtask

  // Reference: every pixel of the unclipped rectangle, kept only if on screen.
  task automatic run_cmd(input string name, input int x0, input int y0, input int w, input int h,
                         input int col, input int inj_a, input int inj_b,
                         output int n, output int dcyc, output int first, output int last);
    int  exp_q[$];
    int  n_model;
    int  pix;
    bit  fin;
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        if (xx < 160 && yy < 120) exp_q.push_back(xx * 256 + yy);
    n_model = exp_q.size();
    n = 0; dcyc = -1; first = -1; last = -1;
    bus.x0 = 8'(x0); bus.y0 = 7'(y0); bus.w = 8'(w); bus.h = 7'(h);
    bus.colour_in = 3'(col);
    bus.start = 1'b1;
    @(posedge Clock);
    #1;
    bus.start = 1'b0;
    scramble_operands();
    fin = 1'b0;
    for (int cyc = 1; cyc <= 20005 && !fin; cyc++) begin
      @(negedge Clock);
      if (bus.plot) begin
        pix = int'(bus.x) * 256 + int'(bus.y);
        if (n == 0) first = pix;
        last = pix;
        if (exp_q.size() == 0) chk({name, " extra plot"}, pix, -1);
        else chk({name, " pixel"}, pix, exp_q.pop_front());
        chk({name, " colour"}, int'(bus.colour), col);
        chk({name, " busy while plot"}, int'(bus.busy), 1);
        n++;
      end
      if (bus.done) begin
        dcyc = cyc;
        fin  = 1'b1;
        chk({name, " plot at done"}, int'(bus.plot), 0);
        chk({name, " busy at done"}, int'(bus.busy), 1);
      end
      bus.start = (cyc == inj_a || cyc == inj_b);
      if (bus.start) scramble_operands();
    end
    if (!fin) chk({name, " done timeout"}, 0, 1);
    chk({name, " done cycle"}, dcyc, n_model + 1);
    @(negedge Clock);
    chk({name, " busy after done"}, int'(bus.busy), 0);
    chk({name, " done width"}, int'(bus.done), 0);
    chk({name, " plot idle"}, int'(bus.plot), 0);
    bus.start = 1'b0;
  endtask

  initial begin
    int n, dcyc, first, last;
    int rx, ry, rw, rh, rc;

    tbl[0] = '{10, 5, 2, 2, 4, 0, 0, 4, 5, 10*256+5, 11*256+6};
    tbl[1] = '{158, 118, 5, 4, 1, 0, 0, 4, 5, 158*256+118, 159*256+119};
    tbl[2] = '{3, 3, 0, 5, 2, 0, 0, 0, 1, -1, -1};
    tbl[3] = '{3, 3, 5, 0, 2, 0, 0, 0, 1, -1, -1};
    tbl[4] = '{200, 3, 5, 5, 2, 0, 0, 0, 1, -1, -1};
    tbl[5] = '{7, 125, 3, 2, 6, 0, 0, 0, 1, -1, -1};
    tbl[6] = '{10, 5, 2, 2, 4, 2, 5, 4, 5, 10*256+5, 11*256+6};
    tbl[7] = '{0, 0, 160, 120, 0, 0, 0, 19200, 19201, 0, 159*256+119};
    tbl[8] = '{159, 119, 1, 1, 7, 0, 0, 1, 2, 159*256+119, 159*256+119};

    bus.start = 1'b0;
    scramble_operands();
    repeat (3) @(negedge Clock);
    chk("reset x", int'(bus.x), 0);
    chk("reset y", int'(bus.y), 0);
    chk("reset colour", int'(bus.colour), 0);
    chk("reset plot", int'(bus.plot), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    Resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].col,
              tbl[i].inj_a, tbl[i].inj_b, n, dcyc, first, last);
      chk($sformatf("vec%0d count", i), n, tbl[i].n);
      chk($sformatf("vec%0d done cycle", i), dcyc, tbl[i].dcyc);
      chk($sformatf("vec%0d first", i), first, tbl[i].first);
      chk($sformatf("vec%0d last", i), last, tbl[i].last);
    end

    for (int i = 0; i < 30; i++) begin
      rx = $urandom_range(0, 175);
      ry = $urandom_range(0, 127);
      rw = $urandom_range(0, 24);
      rh = $urandom_range(0, 12);
      rc = $urandom_range(0, 7);
      run_cmd($sformatf("rand%0d", i), rx, ry, rw, rh, rc, 0, 0, n, dcyc, first, last);
    end

    // Asynchronous reset during the third plot of a 4x4 fill.
    bus.x0 = 8'd20; bus.y0 = 7'd10; bus.w = 8'd4; bus.h = 7'd4; bus.colour_in = 3'd5;
    bus.start = 1'b1;
    @(posedge Clock);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge Clock);
    chk("midfill plot", int'(bus.plot), 1);
    chk("midfill x", int'(bus.x), 22);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async x", int'(bus.x), 0);
    chk("async y", int'(bus.y), 0);
    chk("async colour", int'(bus.colour), 0);
    chk("async plot", int'(bus.plot), 0);
    chk("async busy", int'(bus.busy), 0);
    chk("async done", int'(bus.done), 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      chk("post reset done", int'(bus.done), 0);
      chk("post reset plot", int'(bus.plot), 0);
    end
    run_cmd("after reset", 0, 0, 1, 1, 3, 0, 0, n, dcyc, first, last);
    chk("after reset count", n, 1);
    chk("after reset pixel", first, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
